// File: rtl/ocdve_apb_reg_slave.sv
// APB completer: read-only ID word plus NUM_REGS-1 read/write words.
// Fixed wait-state count, PSLVERR on misaligned/out-of-range/ID writes.
module ocdve_apb_reg_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS = 8,
  parameter int WAIT_STATES = 0,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE = 32'hA5B0_0001
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [ADDR_WIDTH-1:0]          paddr,
  input  logic                           psel,
  input  logic                           penable,
  input  logic                           pwrite,
  input  logic [DATA_WIDTH-1:0]          pwdata,
  output logic                           pready,
  output logic [DATA_WIDTH-1:0]          prdata,
  output logic                           pslverr,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

  localparam int IDXW = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(NUM_REGS * 4);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr;
  logic r_write, w_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic r_pready, w_pready_nxt;
  logic r_pslverr, w_pslverr_nxt;
  logic [DATA_WIDTH-1:0] r_prdata, w_prdata_nxt, w_rdval;
  logic [DATA_WIDTH-1:0] r_regs [1:NUM_REGS-1];
  logic [IDXW-1:0] w_idx;
  logic w_setup, w_err, w_done, w_we, w_cap;

  // Decode from the live bus in IDLE, from the captured copy in ACCESS
  assign w_setup = psel & ~penable;
  assign w_addr  = (r_state == S_IDLE) ? paddr : r_addr;
  assign w_write = (r_state == S_IDLE) ? pwrite : r_write;
  assign w_idx   = w_addr[IDXW+1:2];
  assign w_err   = (w_addr[1:0] != 2'b00) | (w_addr >= LIMIT) |
                   (w_write & (w_idx == '0));

  always_comb begin
    w_rdval = ID_VALUE;
    for (int i = 1; i < NUM_REGS; i++)
      if (w_idx == IDXW'(i)) w_rdval = r_regs[i];
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_cap         = 1'b0;
    w_done        = 1'b0;
    w_we          = 1'b0;
    w_pready_nxt  = 1'b0;
    w_pslverr_nxt = 1'b0;
    w_prdata_nxt  = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_setup) begin
          w_cap       = 1'b1;
          w_cnt_nxt   = WS;
          w_state_nxt = S_ACCESS;
          w_done      = (WS == 4'd0);
        end
      end
      S_ACCESS: begin
        if (!psel) begin
          w_state_nxt = S_IDLE;
        end else if (r_pready) begin
          w_state_nxt = S_IDLE;
          w_we        = r_write & ~r_pslverr;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
          w_done    = (r_cnt == 4'd1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Outputs are registered, so the response is set up one edge early
    if (w_done) begin
      w_pready_nxt  = 1'b1;
      w_pslverr_nxt = w_err;
      w_prdata_nxt  = (!w_err && !w_write) ? w_rdval : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pready  <= w_pready_nxt;
      r_pslverr <= w_pslverr_nxt;
      r_prdata  <= w_prdata_nxt;
      if (w_cap) begin
        r_addr  <= paddr;
        r_write <= pwrite;
        r_wdata <= pwdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 1; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++)
        if (w_we && w_idx == IDXW'(i)) r_regs[i] <= r_wdata;
    end
  end

  assign pready  = r_pready;
  assign pslverr = r_pslverr;
  assign prdata  = r_prdata;

  assign reg_out[DATA_WIDTH-1:0] = ID_VALUE;
  for (genvar g = 1; g < NUM_REGS; g++) begin : g_out
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
  end

endmodule

// File: tb/tb_ocdve_apb_reg_slave.sv
// Bench for ocdve_apb_reg_slave: one instance with no wait states,
// one with three, sharing the bus except for their selects.
module tb_ocdve_apb_reg_slave;

  localparam logic [31:0] ID = 32'hA5B0_0001;
  localparam int NR = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [31:0] paddr = '0;
  logic psel0 = 1'b0, psel1 = 1'b0;
  logic penable = 1'b0, pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic pready0, pready1, pslverr0, pslverr1;
  logic [31:0] prdata0, prdata1;
  logic [NR*32-1:0] reg_out0, reg_out1;

  int checks = 0;
  int failures = 0;
  logic [31:0] m [2][NR];

  always #5 clk = ~clk;

  ocdve_apb_reg_slave #(.WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset_n(reset_n), .paddr(paddr), .psel(psel0),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pready(pready0), .prdata(prdata0), .pslverr(pslverr0),
    .reg_out(reg_out0)
  );

  ocdve_apb_reg_slave #(.WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset_n(reset_n), .paddr(paddr), .psel(psel1),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pready(pready1), .prdata(prdata1), .pslverr(pslverr1),
    .reg_out(reg_out1)
  );

  function automatic logic [NR*32-1:0] exp_ro(input int s);
    logic [NR*32-1:0] v;
    v[31:0] = ID;
    for (int i = 1; i < NR; i++) v[i*32 +: 32] = m[s][i];
    return v;
  endfunction

  function automatic bit exp_err(input logic [31:0] a, input bit w);
    return (a % 4 != 0) || (a >= NR * 4) || (w && a == 0);
  endfunction

  function automatic logic [NR*32-1:0] ro(input int s);
    return (s == 0) ? reg_out0 : reg_out1;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m[s][0] = ID;
      for (int i = 1; i < NR; i++) m[s][i] = '0;
    end
  endtask

  // Starts and ends at posedge+1; acc = -1 if pready never came
  task automatic xfer(input int sel, input logic [31:0] a, input bit w,
                      input logic [31:0] d, output logic [31:0] rd,
                      output logic er, output int acc, output bit quiet);
    bit got;
    paddr = a; pwrite = w; pwdata = d; penable = 1'b0;
    psel0 = (sel == 0); psel1 = (sel == 1);
    @(posedge clk); #1;
    penable = 1'b1;
    paddr = $urandom; pwrite = 1'($urandom); pwdata = $urandom;
    acc = 0; quiet = 1'b1; got = 1'b0; rd = '0; er = 1'b0;
    for (int k = 0; k < 20; k++) begin
      acc++;
      @(negedge clk);
      if ((sel == 0) ? pready0 : pready1) begin
        rd = (sel == 0) ? prdata0 : prdata1;
        er = (sel == 0) ? pslverr0 : pslverr1;
        got = 1'b1;
        break;
      end
      if (((sel == 0) ? prdata0 : prdata1) != 0 ||
          ((sel == 0) ? pslverr0 : pslverr1)) quiet = 1'b0;
      @(posedge clk); #1;
    end
    if (got) begin
      @(posedge clk); #1;
    end else begin
      acc = -1;
    end
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({pready0, pslverr0, prdata0, pready1, pslverr1, prdata1} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got %b/%b/%h %b/%b/%h expected zeros",
               pready0, pslverr0, prdata0, pready1, pslverr1, prdata1);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (ro(s) !== exp_ro(s)) begin
        failures++;
        $display("FAIL reset_regs dut%0d got %h expected %h", s, ro(s), exp_ro(s));
      end
    end
  endtask

  task automatic test_id_read();
    logic [31:0] rd; logic er; int acc; bit q;
    xfer(0, 32'h0, 1'b0, 32'h0, rd, er, acc, q);
    checks++;
    if (rd !== ID || er !== 1'b0 || acc != 1) begin
      failures++;
      $display("FAIL id_read got %h err=%b acc=%0d expected %h err=0 acc=1",
               rd, er, acc, ID);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er; int acc; bit q;
    xfer(0, 32'h4, 1'b1, 32'hDEAD_BEEF, rd, er, acc, q);
    m[0][1] = 32'hDEAD_BEEF;
    checks++;
    if (rd !== '0 || er !== 1'b0 || acc != 1) begin
      failures++;
      $display("FAIL write_resp got %h err=%b acc=%0d expected 0 err=0 acc=1",
               rd, er, acc);
    end
    xfer(0, 32'h4, 1'b0, 32'h0, rd, er, acc, q);
    checks++;
    if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
      failures++;
      $display("FAIL readback got %h err=%b expected deadbeef err=0", rd, er);
    end
    checks++;
    if (reg_out0 !== exp_ro(0)) begin
      failures++;
      $display("FAIL write_regs got %h expected %h", reg_out0, exp_ro(0));
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic er; int acc; bit q;
    time t0;
    t0 = $time;
    xfer(1, 32'h8, 1'b0, 32'h0, rd, er, acc, q);
    checks++;
    if (acc != 4 || !q || rd !== m[1][2] || er !== 1'b0) begin
      failures++;
      $display("FAIL wait_read acc=%0d quiet=%0b rd=%h err=%b expected acc=4 quiet=1 rd=%h",
               acc, q, rd, er, m[1][2]);
    end
    checks++;
    if ($time - t0 != 50) begin
      failures++;
      $display("FAIL wait_duration got %0t expected 50", $time - t0);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int acc; bit q;
    logic [31:0] addrs [4] = '{32'h0, 32'h20, 32'h6, 32'h6};
    bit wr [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 4; i++) begin
        xfer(s, addrs[i], wr[i], $urandom, rd, er, acc, q);
        checks++;
        if (er !== 1'b1 || rd !== '0 || acc != (s == 0 ? 1 : 4) ||
            ro(s) !== exp_ro(s)) begin
          failures++;
          $display("FAIL error_%0d dut%0d got err=%b rd=%h acc=%0d expected err=1 rd=0",
                   i, s, er, rd, acc);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int acc; bit q;
    logic [31:0] v [3];
    time t0;
    t0 = $time;
    for (int i = 0; i < 3; i++) begin
      v[i] = $urandom;
      xfer(0, 32'(4 * (i + 1)), 1'b1, v[i], rd, er, acc, q);
      m[0][i+1] = v[i];
      checks++;
      if (acc != 1 || er !== 1'b0) begin
        failures++;
        $display("FAIL b2b_%0d got acc=%0d err=%b expected acc=1 err=0", i, acc, er);
      end
    end
    checks++;
    if ($time - t0 != 60 || reg_out0 !== exp_ro(0)) begin
      failures++;
      $display("FAIL b2b_total got %0t regs %h expected 60 regs %h",
               $time - t0, reg_out0, exp_ro(0));
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, a, d, erd; logic er; int acc, s, r; bit q, w, ee;
    for (int n = 0; n < 40; n++) begin
      s = $urandom_range(0, 1);
      r = $urandom_range(0, 9);
      if (r < 7) a = 32'($urandom_range(0, NR - 1) * 4);
      else if (r < 9) a = 32'($urandom_range(0, 40));
      else a = $urandom | 32'h100;
      w = 1'($urandom);
      d = $urandom;
      ee = exp_err(a, w);
      erd = (!ee && !w) ? m[s][a/4] : '0;
      xfer(s, a, w, d, rd, er, acc, q);
      if (!ee && w) m[s][a/4] = d;
      checks++;
      if (rd !== erd || er !== ee || acc != (s == 0 ? 1 : 4) || !q ||
          ro(s) !== exp_ro(s)) begin
        failures++;
        $display("FAIL random_%0d dut%0d a=%h w=%0b got rd=%h err=%b acc=%0d q=%0b expected rd=%h err=%b",
                 n, s, a, w, rd, er, acc, q, erd, ee);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int acc; bit q;
    xfer(1, 32'h4, 1'b1, 32'h1234_5678, rd, er, acc, q);
    m[1][1] = 32'h1234_5678;
    // abort a wait-stated write with reset
    paddr = 32'h4; pwrite = 1'b1; pwdata = 32'hCAFE_F00D;
    psel1 = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (pready1 !== 1'b0 || pslverr1 !== 1'b0 || prdata1 !== '0 ||
        reg_out1 !== exp_ro(1)) begin
      failures++;
      $display("FAIL reset_wait got %b/%b/%h regs %h expected zeros regs %h",
               pready1, pslverr1, prdata1, reg_out1, exp_ro(1));
    end
    psel1 = 1'b0; penable = 1'b0;
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    // reset while pready is already high
    paddr = 32'h0; pwrite = 1'b0; psel0 = 1'b1;
    @(posedge clk); #1;
    penable = 1'b1;
    checks++;
    if (pready0 !== 1'b1 || prdata0 !== ID) begin
      failures++;
      $display("FAIL pre_reset_ready got %b/%h expected 1/%h", pready0, prdata0, ID);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (pready0 !== 1'b0 || prdata0 !== '0 || pslverr0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_async got %b/%h/%b expected 0/0/0", pready0, prdata0, pslverr0);
    end
    psel0 = 1'b0; penable = 1'b0;
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    xfer(1, 32'h4, 1'b1, 32'h0BAD_CAFE, rd, er, acc, q);
    m[1][1] = 32'h0BAD_CAFE;
    xfer(1, 32'h4, 1'b0, 32'h0, rd, er, acc, q);
    checks++;
    if (rd !== 32'h0BAD_CAFE || er !== 1'b0 || acc != 4 ||
        reg_out1 !== exp_ro(1)) begin
      failures++;
      $display("FAIL post_reset got %h err=%b acc=%0d expected 0badcafe err=0 acc=4",
               rd, er, acc);
    end
  endtask

  initial begin
    test_reset();
    test_id_read();
    test_write_read();
    test_wait_states();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
